// File: rtl/bram_controller_pkg.sv
// Shared types and constants for the AXI4-Lite to block-RAM bridge.
// Holds the controller state encoding and the fixed data/strobe widths.
package bram_ctrl_pkg;

   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      IDLE,
      RD_DATA,
      RD_RESP,
      WR_RESP
   } state_t;

endpackage

// File: rtl/bram_controller_if.sv
// AXI4-Lite single-beat bus bundle between a CPU memory port and the BRAM bridge.
interface bram_controller_if
   import bram_ctrl_pkg::*;
#(
   parameter int ADDR_W = 16
) ();

   logic [ADDR_W-1:0] awaddr;
   logic [2:0]        awprot;
   logic              awvalid;
   logic              awready;

   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wvalid;
   logic              wready;

   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;

   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arprot;
   logic              arvalid;
   logic              arready;

   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      input  araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
      output araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/bram_controller.sv
// AXI4-Lite slave serving one single-beat transaction at a time onto BRAM port A.
// Reads take one extra cycle to capture the 1-cycle-latency RAM output.
module bram_controller
   import bram_ctrl_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic                s_axi_aclk,
   input  logic                s_axi_aresetn,
   bram_controller_if.slave    s_axi,
   output logic                bram_rst_a,
   output logic                bram_clk_a,
   output logic                bram_en_a,
   output logic [STRB_W-1:0]   bram_we_a,
   output logic [ADDR_W-1:0]   bram_addr_a,
   output logic [DATA_W-1:0]   bram_wrdata_a,
   input  logic [DATA_W-1:0]   bram_rddata_a
);

   state_t            state;
   logic              wr_first;
   logic              bvalid_r;
   logic              rvalid_r;
   logic [DATA_W-1:0] rdata_r;

   logic wr_req;
   logic rd_req;
   logic grant_wr;
   logic grant_rd;

   // Low address bits and prot are deliberately ignored.
   logic unused_bits;
   assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

   assign bram_rst_a = !s_axi_aresetn;
   assign bram_clk_a = s_axi_aclk;

   always_comb begin
      wr_req   = s_axi.awvalid && s_axi.wvalid;
      rd_req   = s_axi.arvalid;
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (s_axi_aresetn && (state == IDLE)) begin
         grant_wr = wr_req && (wr_first || !rd_req);
         grant_rd = rd_req && !grant_wr;
      end
   end

   always_comb begin
      s_axi.awready = grant_wr;
      s_axi.wready  = grant_wr;
      s_axi.arready = grant_rd;
      bram_en_a     = grant_wr || grant_rd;
      bram_we_a     = '0;
      bram_addr_a   = '0;
      bram_wrdata_a = '0;
      if (grant_wr) begin
         bram_we_a     = s_axi.wstrb;
         bram_addr_a   = {s_axi.awaddr[ADDR_W-1:2], 2'b00};
         bram_wrdata_a = s_axi.wdata;
      end else if (grant_rd) begin
         bram_addr_a   = {s_axi.araddr[ADDR_W-1:2], 2'b00};
      end
   end

   assign s_axi.bvalid = bvalid_r;
   assign s_axi.bresp  = RESP_OKAY;
   assign s_axi.rvalid = rvalid_r;
   assign s_axi.rresp  = RESP_OKAY;
   assign s_axi.rdata  = rdata_r;

   // The round-robin pointer only moves when both requests competed for the same cycle.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state    <= IDLE;
         wr_first <= 1'b1;
         bvalid_r <= 1'b0;
         rvalid_r <= 1'b0;
         rdata_r  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_wr) begin
                  state    <= WR_RESP;
                  bvalid_r <= 1'b1;
                  if (rd_req) wr_first <= 1'b0;
               end else if (grant_rd) begin
                  state <= RD_DATA;
                  if (wr_req) wr_first <= 1'b1;
               end
            end
            RD_DATA: begin
               rdata_r  <= bram_rddata_a;
               rvalid_r <= 1'b1;
               state    <= RD_RESP;
            end
            RD_RESP: begin
               if (s_axi.rready) begin
                  rvalid_r <= 1'b0;
                  state    <= IDLE;
               end
            end
            WR_RESP: begin
               if (s_axi.bready) begin
                  bvalid_r <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_controller.sv
// Directed bench for bram_controller with a behavioural 1-cycle-latency RAM on port A.
module tb_bram_controller;
   import bram_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bram_controller_if #(.ADDR_W(16)) axi ();

   logic        bram_rst, bram_clk, bram_en;
   logic [3:0]  bram_we;
   logic [15:0] bram_addr;
   logic [31:0] bram_wrdata;
   logic [31:0] bram_rddata;
   logic [31:0] mem [0:255];

   int checks = 0;
   int failures = 0;

   bram_controller #(.ADDR_W(16)) dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rst_n),
      .s_axi         (axi),
      .bram_rst_a    (bram_rst),
      .bram_clk_a    (bram_clk),
      .bram_en_a     (bram_en),
      .bram_we_a     (bram_we),
      .bram_addr_a   (bram_addr),
      .bram_wrdata_a (bram_wrdata),
      .bram_rddata_a (bram_rddata)
   );

   always @(posedge bram_clk) begin
      if (bram_en) begin
         for (int b = 0; b < 4; b++)
            if (bram_we[b]) mem[bram_addr[9:2]][8*b +: 8] <= bram_wrdata[8*b +: 8];
         bram_rddata <= mem[bram_addr[9:2]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
      nxt();
      axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1;
      #1;
      chk("wr_awready", 32'(axi.awready), 32'd1);
      chk("wr_wready", 32'(axi.wready), 32'd1);
      chk("wr_en", 32'(bram_en), 32'd1);
      chk("wr_we", 32'(bram_we), 32'(strb));
      chk("wr_addr", 32'(bram_addr), {16'h0, addr[15:2], 2'b00});
      chk("wr_data", bram_wrdata, data);
      nxt();
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      #1;
      chk("wr_bvalid", 32'(axi.bvalid), 32'd1);
      chk("wr_bresp", 32'(axi.bresp), 32'd0);
      chk("wr_en_idle", 32'(bram_en), 32'd0);
   endtask

   task automatic do_read(input logic [15:0] addr, input logic [15:0] exp_addr, input logic [31:0] exp);
      nxt();
      axi.araddr = addr; axi.arvalid = 1'b1;
      #1;
      chk("rd_arready", 32'(axi.arready), 32'd1);
      chk("rd_en", 32'(bram_en), 32'd1);
      chk("rd_we", 32'(bram_we), 32'd0);
      chk("rd_addr", 32'(bram_addr), 32'(exp_addr));
      nxt();
      axi.arvalid = 1'b0;
      #1;
      chk("rd_rvalid_n1", 32'(axi.rvalid), 32'd0);
      nxt();
      #1;
      chk("rd_rvalid_n2", 32'(axi.rvalid), 32'd1);
      chk("rd_rdata", axi.rdata, exp);
      chk("rd_rresp", 32'(axi.rresp), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      bram_rddata = 32'h0;
      axi.awaddr = '0; axi.awprot = 3'b0; axi.awvalid = 1'b0;
      axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b1;
      axi.araddr = '0; axi.arprot = 3'b0; axi.arvalid = 1'b0; axi.rready = 1'b1;
      rst_n = 1'b0;

      // Reset state, with all requests pending to show readies are held low.
      nxt();
      axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
      nxt();
      #1;
      chk("rst_awready", 32'(axi.awready), 32'd0);
      chk("rst_wready", 32'(axi.wready), 32'd0);
      chk("rst_arready", 32'(axi.arready), 32'd0);
      chk("rst_bvalid", 32'(axi.bvalid), 32'd0);
      chk("rst_rvalid", 32'(axi.rvalid), 32'd0);
      chk("rst_rdata", axi.rdata, 32'h0);
      chk("rst_en", 32'(bram_en), 32'd0);
      chk("rst_we", 32'(bram_we), 32'd0);
      chk("rst_bram_rst", 32'(bram_rst), 32'd1);
      axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
      nxt();
      rst_n = 1'b1;

      // Contention after reset: write wins, read follows.
      nxt();
      axi.awaddr = 16'h0010; axi.wdata = 32'hDEADBEEF; axi.wstrb = 4'hF;
      axi.araddr = 16'h0010;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
      #1;
      chk("arb1_awready", 32'(axi.awready), 32'd1);
      chk("arb1_arready", 32'(axi.arready), 32'd0);
      chk("arb1_we", 32'(bram_we), 32'hF);
      nxt();
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      #1;
      chk("arb1_bvalid", 32'(axi.bvalid), 32'd1);
      chk("arb1_bresp", 32'(axi.bresp), 32'd0);
      chk("arb1_arready_wresp", 32'(axi.arready), 32'd0);
      nxt();
      #1;
      chk("arb1_rd_grant", 32'(axi.arready), 32'd1);
      chk("arb1_rd_we", 32'(bram_we), 32'd0);
      nxt();
      axi.arvalid = 1'b0;
      nxt();
      #1;
      chk("arb1_rvalid", 32'(axi.rvalid), 32'd1);
      chk("arb1_rdata", axi.rdata, 32'hDEADBEEF);

      // Second contention: read wins, write follows.
      nxt();
      axi.awaddr = 16'h0020; axi.wdata = 32'h11223344; axi.wstrb = 4'hF;
      axi.araddr = 16'h0010;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
      #1;
      chk("arb2_arready", 32'(axi.arready), 32'd1);
      chk("arb2_awready", 32'(axi.awready), 32'd0);
      chk("arb2_wready", 32'(axi.wready), 32'd0);
      nxt();
      axi.arvalid = 1'b0;
      #1;
      chk("arb2_awready_rd", 32'(axi.awready), 32'd0);
      nxt();
      #1;
      chk("arb2_rvalid", 32'(axi.rvalid), 32'd1);
      chk("arb2_rdata", axi.rdata, 32'hDEADBEEF);
      nxt();
      #1;
      chk("arb2_wr_grant", 32'(axi.awready), 32'd1);
      chk("arb2_wr_addr", 32'(bram_addr), 32'h0020);
      nxt();
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      #1;
      chk("arb2_bvalid", 32'(axi.bvalid), 32'd1);

      // Byte-lane write merges into existing word.
      do_write(16'h0020, 32'h00AA0000, 4'b0100);
      do_read(16'h0020, 16'h0020, 32'h11AA3344);

      // Unaligned read address is aligned down.
      do_read(16'h0013, 16'h0010, 32'hDEADBEEF);

      // Lone awvalid is never accepted.
      for (int i = 0; i < 5; i++) begin
         nxt();
         axi.awaddr = 16'h0040; axi.awvalid = 1'b1;
         #1;
         chk("lone_aw_awready", 32'(axi.awready), 32'd0);
         chk("lone_aw_en", 32'(bram_en), 32'd0);
      end
      axi.awvalid = 1'b0;

      // Read response back-pressure.
      axi.rready = 1'b0;
      nxt();
      axi.araddr = 16'h0020; axi.arvalid = 1'b1;
      #1;
      chk("bp_rd_arready", 32'(axi.arready), 32'd1);
      nxt();
      axi.arvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         nxt();
         #1;
         chk("bp_rvalid", 32'(axi.rvalid), 32'd1);
         chk("bp_rdata", axi.rdata, 32'h11AA3344);
      end
      axi.rready = 1'b1;

      // Write response back-pressure with a read waiting behind it.
      axi.bready = 1'b0;
      nxt();
      axi.awaddr = 16'h0030; axi.wdata = 32'h00000055; axi.wstrb = 4'hF;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1;
      #1;
      chk("bp_wr_awready", 32'(axi.awready), 32'd1);
      nxt();
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      axi.araddr = 16'h0030; axi.arvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_bvalid", 32'(axi.bvalid), 32'd1);
         chk("bp_arready", 32'(axi.arready), 32'd0);
         if (i < 2) nxt();
      end
      axi.bready = 1'b1;
      nxt();
      #1;
      chk("bp_rd_grant", 32'(axi.arready), 32'd1);
      nxt();
      axi.arvalid = 1'b0;
      nxt();
      #1;
      chk("bp_rd_rdata", axi.rdata, 32'h00000055);

      // Zero-strobe write: handshake completes, memory untouched.
      do_write(16'h0010, 32'h00000000, 4'b0000);
      do_read(16'h0010, 16'h0010, 32'hDEADBEEF);

      // Reset asserted while the read is in RD_DATA.
      nxt();
      axi.araddr = 16'h0020; axi.arvalid = 1'b1;
      #1;
      chk("rstmid_arready", 32'(axi.arready), 32'd1);
      nxt();
      #1;
      rst_n = 1'b0;
      #1;
      chk("rstmid_rvalid", 32'(axi.rvalid), 32'd0);
      chk("rstmid_rdata", axi.rdata, 32'h0);
      chk("rstmid_arready_low", 32'(axi.arready), 32'd0);
      chk("rstmid_en", 32'(bram_en), 32'd0);
      nxt();
      axi.arvalid = 1'b0;
      rst_n = 1'b1;
      do_read(16'h0010, 16'h0010, 32'hDEADBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
